// File: rtl/dtack_generator_if.sv
// 68000 bus-side signal bundle between the address decoder/CPU and the DTACK generator.
interface dtack_generator_if;
  logic AS_L;
  logic UDS_L;
  logic LDS_L;
  logic OnChipRomSelect_H;
  logic OnChipRamSelect_H;
  logic IOSelect_H;
  logic VGASelect_H;
  logic DramSelect_H;
  logic CanBusSelect_H;
  logic DramDtack_L;
  logic CanBusDtack_L;
  logic DtackOut_L;
  logic BErr_L;
  logic Busy_H;

  modport master (
    output AS_L, UDS_L, LDS_L,
    output OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, VGASelect_H,
    output DramSelect_H, CanBusSelect_H, DramDtack_L, CanBusDtack_L,
    input  DtackOut_L, BErr_L, Busy_H
  );

  modport slave (
    input  AS_L, UDS_L, LDS_L,
    input  OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, VGASelect_H,
    input  DramSelect_H, CanBusSelect_H, DramDtack_L, CanBusDtack_L,
    output DtackOut_L, BErr_L, Busy_H
  );
endinterface

// File: rtl/dtack_generator.sv
// 68000 DTACK/BERR generator: counted wait states for internal regions, pass-through acks for external ones.
// Optional bus-error watchdog enabled by defining BUS_ERROR_TIMEOUT_EN.
module dtack_generator #(
  parameter int unsigned ROM_WAIT = 0,
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2,
  parameter int unsigned VGA_WAIT = 3,
  parameter int unsigned TIMEOUT  = 1023
) (
  input logic              Clk,
  input logic              Reset_L,
  dtack_generator_if.slave bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, BERR} stateT;
  typedef enum logic [2:0] {RG_NONE, RG_ROM, RG_IO, RG_CAN, RG_RAM, RG_DRAM, RG_VGA} regionT;

  stateT            state, stateNext;
  regionT           region, regionNext, decodedRegion;
  logic [CNT_W-1:0] waitCnt, waitCntNext, decodedWait;
  logic             armed, armedNext;
  logic             dtackQ, dtackNext;
  logic             berrQ, berrNext;
  logic             busyQ;
  logic             strobe, asHigh, extAck, internalRegion, timedOut;

  assign asHigh = bus.AS_L;
  assign strobe = !bus.AS_L && (!bus.UDS_L || !bus.LDS_L);
  assign extAck = ((region == RG_DRAM) && !bus.DramDtack_L) ||
                  ((region == RG_CAN)  && !bus.CanBusDtack_L);
  assign internalRegion = (region == RG_ROM) || (region == RG_IO) ||
                          (region == RG_RAM) || (region == RG_VGA);

  // Fixed-priority region decode: ROM > IO > CAN > RAM > DRAM > VGA
  always_comb begin
    decodedRegion = RG_NONE;
    decodedWait   = '0;
    if (bus.OnChipRomSelect_H) begin
      decodedRegion = RG_ROM;
      decodedWait   = CNT_W'(ROM_WAIT);
    end else if (bus.IOSelect_H) begin
      decodedRegion = RG_IO;
      decodedWait   = CNT_W'(IO_WAIT);
    end else if (bus.CanBusSelect_H) begin
      decodedRegion = RG_CAN;
    end else if (bus.OnChipRamSelect_H) begin
      decodedRegion = RG_RAM;
      decodedWait   = CNT_W'(RAM_WAIT);
    end else if (bus.DramSelect_H) begin
      decodedRegion = RG_DRAM;
    end else if (bus.VGASelect_H) begin
      decodedRegion = RG_VGA;
      decodedWait   = CNT_W'(VGA_WAIT);
    end
  end

`ifdef BUS_ERROR_TIMEOUT_EN
  logic [CNT_W-1:0] toCnt, toCntNext;
  logic             toClear;

  assign timedOut  = (toCnt == CNT_W'(TIMEOUT));
  assign toClear   = (state == IDLE);
  assign toCntNext = toClear ? '0 : (timedOut ? toCnt : toCnt + CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      toCnt <= '0;
    end else begin
      toCnt <= toCntNext;
    end
  end
`else
  assign timedOut = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    stateNext   = state;
    regionNext  = region;
    waitCntNext = waitCnt;
    armedNext   = armed | asHigh;
    dtackNext   = 1'b1;
    berrNext    = 1'b1;
    case (state)
      IDLE: begin
        // armed blocks a strobe that was already low when reset released
        if (strobe && armed) begin
          stateNext   = WAIT;
          regionNext  = decodedRegion;
          waitCntNext = decodedWait;
          armedNext   = 1'b0;
        end
      end
      WAIT: begin
        if (waitCnt != '0) waitCntNext = waitCnt - CNT_W'(1);
        if (asHigh) begin
          stateNext = IDLE;
        end else if ((internalRegion && (waitCnt == '0)) || extAck) begin
          stateNext = ACK;
          dtackNext = 1'b0;
        end else if (timedOut) begin
          stateNext = BERR;
          berrNext  = 1'b0;
        end
      end
      ACK: begin
        if (asHigh) stateNext = IDLE;
        else        dtackNext = 1'b0;
      end
      BERR: begin
        if (asHigh) stateNext = IDLE;
        else        berrNext  = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      state   <= IDLE;
      region  <= RG_NONE;
      waitCnt <= '0;
      armed   <= 1'b0;
      dtackQ  <= 1'b1;
      berrQ   <= 1'b1;
      busyQ   <= 1'b0;
    end else begin
      state   <= stateNext;
      region  <= regionNext;
      waitCnt <= waitCntNext;
      armed   <= armedNext;
      dtackQ  <= dtackNext;
      berrQ   <= berrNext;
      busyQ   <= (stateNext != IDLE);
    end
  end

  assign bus.DtackOut_L = dtackQ;
  assign bus.BErr_L     = berrQ;
  assign bus.Busy_H     = busyQ;
endmodule
